// File: rtl/down_counter_pkg.sv
// Shared types for the loadable down-counter/timer.
package down_counter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage : down_counter_pkg

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer: counts a programmed value to zero on en,
// pulses tc at the terminal event, optionally reloads for periodic ticks.
module down_counter_timer
  import down_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc
);

  state_t           state_q;
  state_t           state_nxt;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] reload_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] eff_val;
  logic             tc_nxt;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count    <= '0;
      reload_q <= '0;
      tc       <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      count    <= count_nxt;
      reload_q <= reload_nxt;
      tc       <= tc_nxt;
      busy     <= (state_nxt == RUN);
    end
  end

  // Next-state, next-count and terminal-count decode
  always_comb begin
    state_nxt  = state_q;
    count_nxt  = count;
    reload_nxt = reload_q;
    tc_nxt     = 1'b0;
    eff_val    = load ? load_val : count;

    unique case (state_q)
      IDLE: begin
        if (load) begin
          count_nxt  = load_val;
          reload_nxt = load_val;
        end
        if (start) begin
          // A zero-length timer fires tc without ever entering RUN
          if (eff_val != '0) begin
            state_nxt = RUN;
          end else begin
            tc_nxt = 1'b1;
          end
        end
      end

      RUN: begin
        if (load) begin
          reload_nxt = load_val;
        end
        if (stop) begin
          state_nxt = IDLE;
        end else if (en) begin
          if (count > WIDTH'(1)) begin
            count_nxt = count - WIDTH'(1);
          end else if (count == WIDTH'(1)) begin
            tc_nxt = 1'b1;
            if (auto_reload && (reload_q != '0)) begin
              count_nxt = reload_q;
            end else begin
              count_nxt = '0;
              state_nxt = IDLE;
            end
          end else begin
            // count==0 cannot occur in RUN; fall back to IDLE rather than wrap
            state_nxt = IDLE;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule : down_counter_timer
